// File: rtl/sargantana_icache_pkg.sv
// Shared types and default line geometry for the icache IFILL memory-side responder.
package sargantana_icache_pkg;

  localparam int unsigned IFILL_PADDR_W = 40;
  localparam int unsigned IFILL_LINE_W  = 128;
  localparam int unsigned IFILL_BEAT_W  = 64;

  function automatic int unsigned beat_idx_w(input int unsigned n_beats);
    return (n_beats > 1) ? $clog2(n_beats) : 1;
  endfunction

  localparam int unsigned IFILL_N_BEATS    = IFILL_LINE_W / IFILL_BEAT_W;
  localparam int unsigned IFILL_BEAT_IDX_W = beat_idx_w(IFILL_N_BEATS);
  localparam int unsigned IFILL_LINE_OFF_W = $clog2(IFILL_LINE_W / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    RECV  = 2'd2,
    DRAIN = 2'd3
  } ifill_resp_state_t;

  typedef struct packed {
    logic [IFILL_BEAT_W-1:0]     data;
    logic [IFILL_BEAT_IDX_W-1:0] beat;
    logic                        last;
    logic                        error;
  } ifill_beat_t;

endpackage

// File: rtl/sargantana_icache_ifill_resp.sv
// Memory-side IFILL responder: one line-aligned read per fill, beats returned
// through a registered output stage; a kill drains the remaining beats silently.
module sargantana_icache_ifill_resp
  import sargantana_icache_pkg::*;
#(
  parameter  int unsigned PADDR_W    = IFILL_PADDR_W,
  parameter  int unsigned LINE_W     = IFILL_LINE_W,
  parameter  int unsigned BEAT_W     = IFILL_BEAT_W,
  localparam int unsigned N_BEATS    = LINE_W / BEAT_W,
  localparam int unsigned BEAT_IDX_W = beat_idx_w(N_BEATS)
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  ifill_req_valid_i,
  input  logic [PADDR_W-1:0]    ifill_req_paddr_i,
  input  logic                  ifill_kill_i,
  output logic                  ifill_sent_ack_o,
  output logic                  ifill_resp_valid_o,
  output logic [BEAT_W-1:0]     ifill_resp_data_o,
  output logic [BEAT_IDX_W-1:0] ifill_resp_beat_o,
  output logic                  ifill_resp_last_o,
  output logic                  ifill_resp_error_o,
  output logic                  mem_req_valid_o,
  output logic [PADDR_W-1:0]    mem_req_addr_o,
  input  logic                  mem_req_ready_i,
  input  logic                  mem_resp_valid_i,
  input  logic [BEAT_W-1:0]     mem_resp_data_i,
  input  logic                  mem_resp_error_i
);

  localparam int unsigned LINE_OFF_W = $clog2(LINE_W / 8);
  localparam logic [PADDR_W-1:0] OFF_MASK = PADDR_W'((64'd1 << LINE_OFF_W) - 64'd1);
  localparam logic [BEAT_IDX_W-1:0] CNT_LAST = BEAT_IDX_W'(N_BEATS - 1);

  ifill_resp_state_t     state_q, state_d;
  logic [BEAT_IDX_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic                  killed_q, killed_d;
  logic                  err_q, err_d;
  logic [PADDR_W-1:0]    addr_q, addr_d;
  ifill_beat_t           out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic                  ack_q, ack_d;
  logic                  last_beat;

  assign last_beat = (cnt_q == CNT_LAST);
  assign cnt_inc   = last_beat ? '0 : cnt_q + BEAT_IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    killed_d    = killed_q;
    err_d       = err_q;
    addr_d      = addr_q;
    out_d       = out_q;
    out_d.last  = 1'b0;
    out_d.error = 1'b0;
    out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // ack_q still high while the last beat is on the output: no accept yet
        if (ifill_req_valid_i && !ifill_kill_i && !ack_q) begin
          state_d  = SEND;
          addr_d   = ifill_req_paddr_i & ~OFF_MASK;
          cnt_d    = '0;
          killed_d = 1'b0;
          err_d    = 1'b0;
        end
      end
      SEND: begin
        if (ifill_kill_i) killed_d = 1'b1;
        if (mem_req_ready_i) state_d = (killed_q || ifill_kill_i) ? DRAIN : RECV;
      end
      RECV: begin
        if (mem_resp_valid_i) begin
          cnt_d = cnt_inc;
          err_d = err_q | mem_resp_error_i;
        end
        // A beat coinciding with the kill is still counted so the drain ends on time
        if (ifill_kill_i) begin
          killed_d = 1'b1;
          state_d  = (mem_resp_valid_i && last_beat) ? IDLE : DRAIN;
        end else if (mem_resp_valid_i) begin
          out_valid_d = 1'b1;
          out_d.data  = mem_resp_data_i;
          out_d.beat  = cnt_q;
          out_d.last  = last_beat;
          out_d.error = last_beat & (err_q | mem_resp_error_i);
          if (last_beat) state_d = IDLE;
        end
      end
      DRAIN: begin
        if (mem_resp_valid_i) begin
          cnt_d = cnt_inc;
          if (last_beat) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    ack_d = (state_d != IDLE) || (out_valid_d && out_d.last);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      killed_q    <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      killed_q    <= killed_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      ack_q       <= ack_d;
    end
  end

  assign ifill_sent_ack_o   = ack_q;
  assign ifill_resp_valid_o = out_valid_q;
  assign ifill_resp_data_o  = out_q.data;
  assign ifill_resp_beat_o  = out_q.beat;
  assign ifill_resp_last_o  = out_q.last;
  assign ifill_resp_error_o = out_q.error;
  assign mem_req_valid_o    = (state_q == SEND);
  assign mem_req_addr_o     = addr_q;

endmodule
